// File: rtl/htif_tohost_responder_if.sv
// Memory port and console stream between the core-side interconnect and the
// HTIF tohost/fromhost responder.
interface htif_tohost_responder_if;
    logic        req_i;
    logic        we_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;
    logic [7:0]  be_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [63:0] rdata_o;
    logic        char_valid_o;
    logic [7:0]  char_o;
    logic        char_ready_i;

    // Responder side.
    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i, char_ready_i,
        output gnt_o, rvalid_o, rdata_o, char_valid_o, char_o
    );

    // Core / console-sink side.
    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i, char_ready_i,
        input  gnt_o, rvalid_o, rdata_o, char_valid_o, char_o
    );
endinterface

// File: rtl/htif_tohost_responder.sv
// Host-side HTIF mailbox: serves tohost/fromhost accesses, decodes exit and
// console-putchar commands, streams characters out and drives end_of_test.
module htif_tohost_responder #(
    parameter logic [63:0] TOHOST_ADDR    = 64'h8000_1000,
    parameter logic [63:0] FROMHOST_ADDR  = 64'h8000_1040,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    htif_tohost_responder_if.slave        bus,
    output logic [31:0]                   end_of_test_o,
    output logic                          busy_o
);
    typedef enum logic [2:0] {IDLE, DECODE, CHAR_OUT, ACK, DONE} state_t;

    localparam logic [31:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES;

    state_t      state_q, state_d;
    logic [63:0] tohost_q, fromhost_q, rdata_q, read_data;
    logic [31:0] counter_q, eot_q;
    logic [7:0]  char_q, dev, cmd;
    logic        rvalid_q;
    logic        gnt, hit_tohost, hit_fromhost, wr_tohost, wr_fromhost, rd_access;
    logic        trigger, timeout_hit;
    logic        do_exit, do_char, do_ack, do_timeout;
    logic        unused_addr_bits;

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                                input logic [63:0] new_val,
                                                input logic [7:0]  be);
        logic [63:0] r;
        r = old_val;
        for (int b = 0; b < 8; b++) begin
            if (be[b]) r[8*b +: 8] = new_val[8*b +: 8];
        end
        return r;
    endfunction

    // Word-granular decode: the byte offset inside the 64-bit register is irrelevant.
    assign unused_addr_bits = ^bus.addr_i[2:0];
    assign hit_tohost   = (bus.addr_i[63:3] == TOHOST_ADDR[63:3]);
    assign hit_fromhost = (bus.addr_i[63:3] == FROMHOST_ADDR[63:3]);

    assign gnt         = bus.req_i && (state_q == IDLE || state_q == DONE);
    assign wr_tohost   = gnt && bus.we_i && hit_tohost;
    assign wr_fromhost = gnt && bus.we_i && hit_fromhost;
    assign rd_access   = gnt && !bus.we_i;
    // The high byte lane completes a command; in DONE writes only merge.
    assign trigger     = wr_tohost && bus.be_i[7] && (state_q == IDLE);

    assign dev = tohost_q[63:56];
    assign cmd = tohost_q[55:48];

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (counter_q >= TIMEOUT_LIMIT) &&
                         (state_q != DONE);

    assign read_data = hit_tohost   ? tohost_q   :
                       hit_fromhost ? fromhost_q : 64'h0;

    assign bus.gnt_o        = gnt;
    assign bus.rvalid_o     = rvalid_q;
    assign bus.rdata_o      = rdata_q;
    // A timeout retracts the character in the very cycle it fires.
    assign bus.char_valid_o = (state_q == CHAR_OUT) && !timeout_hit;
    assign bus.char_o       = char_q;
    assign end_of_test_o    = eot_q;
    assign busy_o           = (state_q == DECODE) || (state_q == CHAR_OUT) || (state_q == ACK);

    // Free-running, saturating cycle counter for the watchdog timeout.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst_i) begin
            counter_q <= 32'h0;
        end else if (counter_q != 32'hFFFF_FFFF) begin
            counter_q <= counter_q + 32'h1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic and one-cycle action strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d    = state_q;
        do_exit    = 1'b0;
        do_char    = 1'b0;
        do_ack     = 1'b0;
        do_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger) state_d = DECODE;
            end
            DECODE: begin
                if (dev == 8'h00 && tohost_q[0]) begin
                    do_exit = 1'b1;
                    state_d = DONE;
                end else if (dev == 8'h01 && cmd == 8'h01) begin
                    do_char = 1'b1;
                    state_d = CHAR_OUT;
                end else begin
                    state_d = ACK;
                end
            end
            CHAR_OUT: begin
                if (bus.char_ready_i) state_d = ACK;
            end
            ACK: begin
                do_ack  = 1'b1;
                state_d = IDLE;
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        // An exit decoded in the same cycle beats the timeout.
        if (timeout_hit && !do_exit) begin
            do_timeout = 1'b1;
            state_d    = DONE;
        end
    end

    // Mailbox registers, response path, character latch and end-of-test word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tohost_q   <= 64'h0;
            fromhost_q <= 64'h0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 64'h0;
            char_q     <= 8'h0;
            eot_q      <= 32'h0;
        end else begin
            rvalid_q <= gnt;
            rdata_q  <= rd_access ? read_data : 64'h0;

            if (do_ack)         tohost_q <= 64'h0;
            else if (wr_tohost) tohost_q <= merge_bytes(tohost_q, bus.wdata_i, bus.be_i);

            if (do_ack)           fromhost_q <= {dev, cmd, 48'h0};
            else if (wr_fromhost) fromhost_q <= merge_bytes(fromhost_q, bus.wdata_i, bus.be_i);

            if (do_char) char_q <= tohost_q[7:0];

            if (do_exit)         eot_q <= tohost_q[31:0];
            else if (do_timeout) eot_q <= 32'hFFFF_FFFF;
        end
    end
endmodule

// File: tb/tb_htif_tohost_responder.sv
// Self-checking bench for htif_tohost_responder: scoreboarded read/write
// responses and console characters plus per-scenario timing checks.
module tb_htif_tohost_responder;
    localparam logic [63:0] TOHOST   = 64'h8000_1000;
    localparam logic [63:0] FROMHOST = 64'h8000_1040;
    localparam logic [63:0] OTHER    = 64'h8000_2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] eot, eot_n;
    logic        busy, busy_n;
    int          checks = 0;
    int          errors = 0;
    int          w;
    logic [63:0] rd_q[$];
    logic [7:0]  ch_q[$];
    logic [63:0] exp_rd;

    always #5 clk = ~clk;

    htif_tohost_responder_if bus ();
    htif_tohost_responder_if bus_n ();

    htif_tohost_responder #(.TIMEOUT_CYCLES(50)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus), .end_of_test_o(eot), .busy_o(busy)
    );

    htif_tohost_responder #(.TIMEOUT_CYCLES(0)) dut_n (
        .clk_i(clk), .rst_i(rst), .bus(bus_n), .end_of_test_o(eot_n), .busy_o(busy_n)
    );

    // Response scoreboard: every rvalid pops one expected rdata.
    always @(negedge clk) begin
        if (bus.rvalid_o === 1'b1) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rvalid_unexpected: got rdata %h, no response expected", bus.rdata_o);
            end else begin
                exp_rd = rd_q.pop_front();
                if (bus.rdata_o !== exp_rd) begin
                    errors++;
                    $display("FAIL rdata: got %h expected %h", bus.rdata_o, exp_rd);
                end
            end
        end
    end

    // Character scoreboard: char_o must match and stay stable while valid.
    always @(negedge clk) begin
        if (bus.char_valid_o === 1'b1) begin
            checks++;
            if (ch_q.size() == 0) begin
                errors++;
                $display("FAIL char_unexpected: got %h, no character expected", bus.char_o);
            end else begin
                if (bus.char_o !== ch_q[0]) begin
                    errors++;
                    $display("FAIL char_data: got %h expected %h", bus.char_o, ch_q[0]);
                end
                if (bus.char_ready_i === 1'b1) void'(ch_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.req_i   = 1'b0;
        bus.we_i    = 1'b0;
        bus.addr_i  = 64'h0;
        bus.wdata_i = 64'h0;
        bus.be_i    = 8'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_idle();
        bus.char_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rd_q.delete();
        ch_q.delete();
    endtask

    // Starts just after a rising edge; returns at the falling edge of the
    // cycle after the grant, having checked rvalid there.
    task automatic access(input logic we, input logic [63:0] addr, input logic [63:0] data,
                          input logic [7:0] be, input logic [63:0] exp_data, output int waited);
        waited = 0;
        bus.req_i = 1'b1; bus.we_i = we; bus.addr_i = addr; bus.wdata_i = data; bus.be_i = be;
        @(negedge clk);
        while (bus.gnt_o !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (bus.gnt_o !== 1'b1) begin
            checks++; errors++;
            $display("FAIL gnt_timeout: got gnt %b expected 1 within 20 cycles", bus.gnt_o);
            bus_idle();
            return;
        end
        rd_q.push_back(we ? 64'h0 : exp_data);
        next_cycle();
        bus_idle();
        @(negedge clk);
        checks++;
        if (bus.rvalid_o !== 1'b1) begin
            errors++;
            $display("FAIL rvalid_latency: got %b expected 1", bus.rvalid_o);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({bus.gnt_o, bus.rvalid_o, bus.rdata_o, bus.char_valid_o, bus.char_o, eot, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt %b rvalid %b rdata %h cv %b char %h eot %h busy %b expected all 0",
                     bus.gnt_o, bus.rvalid_o, bus.rdata_o, bus.char_valid_o, bus.char_o, eot, busy);
        end
        next_cycle(); access(1'b0, TOHOST, 64'h0, 8'h00, 64'h0, w);
        next_cycle(); access(1'b0, FROMHOST, 64'h0, 8'h00, 64'h0, w);
    endtask

    task automatic test_exit();
        do_reset();
        access(1'b1, TOHOST, 64'h0000_0000_0000_002B, 8'hFF, 64'h0, w);
        checks++;
        if (busy !== 1'b1 || eot !== 32'h0) begin
            errors++;
            $display("FAIL exit_decode: got busy %b eot %h expected 1 0", busy, eot);
        end
        @(negedge clk);
        checks++;
        if (eot !== 32'h2B || busy !== 1'b0) begin
            errors++;
            $display("FAIL exit_word: got eot %h busy %b expected 0000002b 0", eot, busy);
        end
        next_cycle(); access(1'b1, TOHOST, 64'h0000_0000_0000_0055, 8'hFF, 64'h0, w);
        next_cycle(); access(1'b0, TOHOST, 64'h0, 8'h00, 64'h0000_0000_0000_0055, w);
        next_cycle(); access(1'b1, FROMHOST, 64'h99, 8'h01, 64'h0, w);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (eot !== 32'h2B) begin
                errors++;
                $display("FAIL exit_sticky: cycle %0d got eot %h expected 0000002b", i, eot);
            end
        end
    endtask

    task automatic test_putchar();
        do_reset();
        ch_q.push_back(8'h41);
        access(1'b1, TOHOST, 64'h0101_0000_0000_0041, 8'hFF, 64'h0, w);
        checks++;
        if (bus.char_valid_o !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL putchar_decode: got cv %b busy %b expected 0 1", bus.char_valid_o, busy);
        end
        next_cycle();
        for (int i = 0; i < 6; i++) begin
            bus.char_ready_i = (i == 5);
            @(negedge clk);
            checks++;
            if (bus.char_valid_o !== 1'b1 || bus.char_o !== 8'h41) begin
                errors++;
                $display("FAIL putchar_hold: cycle %0d got cv %b char %h expected 1 41", i, bus.char_valid_o, bus.char_o);
            end
            next_cycle();
        end
        bus.char_ready_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.char_valid_o !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL putchar_ack: got cv %b busy %b expected 0 1", bus.char_valid_o, busy);
        end
        next_cycle(); access(1'b0, TOHOST, 64'h0, 8'h00, 64'h0, w);
        checks++;
        if (w != 0) begin
            errors++;
            $display("FAIL putchar_idle_grant: got %0d stall cycles expected 0", w);
        end
        next_cycle(); access(1'b0, FROMHOST, 64'h0, 8'h00, 64'h0101_0000_0000_0000, w);
    endtask

    task automatic test_split();
        do_reset();
        access(1'b1, TOHOST, 64'h0000_0000_0000_0001, 8'h0F, 64'h0, w);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL split_low_no_trigger: got busy %b expected 0", busy);
        end
        next_cycle(); access(1'b1, TOHOST, 64'h0, 8'hF0, 64'h0, w);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL split_high_trigger: got busy %b expected 1", busy);
        end
        @(negedge clk);
        checks++;
        if (eot !== 32'h1) begin
            errors++;
            $display("FAIL split_exit: got eot %h expected 00000001", eot);
        end
    endtask

    task automatic test_stall();
        do_reset();
        ch_q.push_back(8'h42);
        access(1'b1, TOHOST, 64'h0101_0000_0000_0042, 8'hFF, 64'h0, w);
        next_cycle();
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = FROMHOST;
        for (int i = 0; i < 4; i++) begin
            bus.char_ready_i = (i == 3);
            @(negedge clk);
            checks++;
            if (bus.gnt_o !== 1'b0 || bus.char_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL stall_charout: cycle %0d got gnt %b cv %b expected 0 1", i, bus.gnt_o, bus.char_valid_o);
            end
            next_cycle();
        end
        bus.char_ready_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.gnt_o !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_ack: got gnt %b busy %b expected 0 1", bus.gnt_o, busy);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: got gnt %b expected 1", bus.gnt_o);
        end else begin
            rd_q.push_back(64'h0101_0000_0000_0000);
        end
        next_cycle();
        bus_idle();
        @(negedge clk);
        checks++;
        if (bus.rvalid_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_rvalid: got %b expected 1", bus.rvalid_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] addrs [4];
        logic [63:0] exps  [4];
        do_reset();
        access(1'b1, TOHOST, 64'h0000_0000_1234_5678, 8'h0F, 64'h0, w);
        next_cycle(); access(1'b1, FROMHOST, 64'hDEAD_BEEF_0000_0000, 8'hFF, 64'h0, w);
        next_cycle(); access(1'b1, OTHER, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0, w);
        next_cycle(); access(1'b1, TOHOST, 64'hAAAA_BBBB_CCCC_DDDD, 8'h30, 64'h0, w);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL partial_no_trigger: got busy %b expected 0", busy);
        end
        addrs = '{TOHOST, FROMHOST + 64'h5, OTHER, TOHOST + 64'h7};
        exps  = '{64'h0000_BBBB_1234_5678, 64'hDEAD_BEEF_0000_0000, 64'h0, 64'h0000_BBBB_1234_5678};
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = addrs[i];
            @(negedge clk);
            checks++;
            if (bus.gnt_o !== 1'b1) begin
                errors++;
                $display("FAIL b2b_grant: read %0d got gnt %b expected 1", i, bus.gnt_o);
            end else begin
                rd_q.push_back(exps[i]);
            end
            next_cycle();
        end
        bus_idle();
        // Unknown command: dev 0 with bit0 clear only acknowledges.
        access(1'b1, TOHOST, 64'h0, 8'hC0, 64'h0, w);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL unknown_decode: got busy %b expected 1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || bus.char_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL unknown_ack: got busy %b cv %b expected 1 0", busy, bus.char_valid_o);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || eot !== 32'h0) begin
            errors++;
            $display("FAIL unknown_idle: got busy %b eot %h expected 0 0", busy, eot);
        end
        next_cycle(); access(1'b0, TOHOST, 64'h0, 8'h00, 64'h0, w);
        next_cycle(); access(1'b0, FROMHOST, 64'h0, 8'h00, 64'h0, w);
    endtask

    task automatic test_timeout();
        do_reset();
        repeat (50) next_cycle();
        @(negedge clk);
        checks++;
        if (eot !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: cycle 50 got eot %h busy %b expected 0 0", eot, busy);
        end
        @(negedge clk);
        checks++;
        if (eot !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL timeout_word: cycle 51 got eot %h expected ffffffff", eot);
        end
        next_cycle(); access(1'b0, TOHOST, 64'h0, 8'h00, 64'h0, w);
    endtask

    task automatic test_timeout_char();
        do_reset();
        repeat (46) next_cycle();
        ch_q.push_back(8'h44);
        access(1'b1, TOHOST, 64'h0101_0000_0000_0044, 8'hFF, 64'h0, w);
        for (int c = 48; c <= 50; c++) begin
            @(negedge clk);
            checks++;
            if (bus.char_valid_o !== (c != 50) || busy !== 1'b1) begin
                errors++;
                $display("FAIL timeout_char: cycle %0d got cv %b busy %b expected %b 1", c, bus.char_valid_o, busy, c != 50);
            end
        end
        @(negedge clk);
        checks++;
        if (eot !== 32'hFFFF_FFFF || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_char_done: got eot %h busy %b expected ffffffff 0", eot, busy);
        end
        ch_q.delete();
    endtask

    task automatic test_timeout_exit();
        do_reset();
        repeat (49) next_cycle();
        access(1'b1, TOHOST, 64'h0000_0000_0000_0777, 8'hFF, 64'h0, w);
        @(negedge clk);
        checks++;
        if (eot !== 32'h777) begin
            errors++;
            $display("FAIL timeout_vs_exit: got eot %h expected 00000777", eot);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        access(1'b1, FROMHOST, 64'h1111, 8'hFF, 64'h0, w);
        ch_q.push_back(8'h43);
        next_cycle(); access(1'b1, TOHOST, 64'h0101_0000_0000_0043, 8'hFF, 64'h0, w);
        @(negedge clk);
        checks++;
        if (bus.char_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_setup: got cv %b expected 1", bus.char_valid_o);
        end
        next_cycle();
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.char_valid_o !== 1'b0 || busy !== 1'b0 || eot !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: got cv %b busy %b eot %h expected 0 0 0", bus.char_valid_o, busy, eot);
        end
        ch_q.delete();
        next_cycle();
        rst = 1'b0;
        access(1'b0, TOHOST, 64'h0, 8'h00, 64'h0, w);
        next_cycle(); access(1'b0, FROMHOST, 64'h0, 8'h00, 64'h0, w);
    endtask

    initial begin
        bus_idle();
        bus.char_ready_i = 1'b0;
        bus_n.req_i = 1'b0; bus_n.we_i = 1'b0; bus_n.addr_i = 64'h0;
        bus_n.wdata_i = 64'h0; bus_n.be_i = 8'h0; bus_n.char_ready_i = 1'b0;

        test_reset();
        test_exit();
        test_putchar();
        test_split();
        test_stall();
        test_back_to_back();
        test_timeout();
        test_timeout_char();
        test_timeout_exit();
        test_reset_mid();

        repeat (3) @(negedge clk);
        checks++;
        if (eot_n !== 32'h0 || busy_n !== 1'b0) begin
            errors++;
            $display("FAIL timeout_disabled: got eot %h busy %b expected 0 0", eot_n, busy_n);
        end
        checks++;
        if (rd_q.size() != 0 || ch_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d responses %0d chars pending expected 0 0", rd_q.size(), ch_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/htif_tohost_responder.md
# htif_tohost_responder

Host-side responder for the HTIF tohost/fromhost mailbox, the target end of the protocol whose tohost writes the core's commit tracing only observes. It sits on a dedicated memory port that the testbench interconnect decodes for the two mailbox addresses. It does the following:
- accepts core reads and writes of the two mailbox registers;
- decodes exit and console-putchar commands;
- streams characters out through a valid/ready port;
- acknowledges each command through fromhost;
- drives the 32-bit end-of-test word that the benches already use for termination.

## Interface
- TOHOST_ADDR, 64'h8000_1000: byte address of the 64-bit tohost register. Must be 8-byte aligned.
- FROMHOST_ADDR, 64'h8000_1040: byte address of the 64-bit fromhost register. Must be 8-byte aligned.
- TIMEOUT_CYCLES, 2000000: cycles after reset before a forced timeout. 0 disables the timeout.
- clk_i  in  1  clock. The block has one clock.
- rst_i  in  1  reset. Synchronous, active-high.
- req_i  in  1  memory request.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  64  byte address. Bits [2:0] are ignored.
- wdata_i  in  64  write data, lane-aligned.
- be_i  in  8  byte enables.
- gnt_o  out  1  request accepted this cycle.
- rvalid_o  out  1  response valid. Issued for both reads and writes.
- rdata_o  out  64  read data.
- char_valid_o  out  1  console character valid.
- char_o  out  8  console character.
- char_ready_i  in  1  character consumed.
- end_of_test_o  out  32  bit0 = finished. Holds an exit word or 32'hFFFF_FFFF.
- busy_o  out  1  a command is in progress, i.e. the FSM is not in IDLE or DONE.

## Operation
- Registers: tohost_q[63:0] and fromhost_q[63:0].
  - Writes merge byte-wise under be_i.
  - Addresses other than the two mailbox addresses: writes are dropped, reads return 0.
- gnt_o = req_i && (state == IDLE || state == DONE). A request held during a busy state is stalled.
- FSM states: IDLE, DECODE, CHAR_OUT, ACK, DONE.
- IDLE:
  - A granted write to TOHOST_ADDR with be_i[7] = 1 is the trigger (the high word completes the command; RV32 software writes the low word first). It merges the data and moves to DECODE.
  - All other granted accesses stay in IDLE.
- DECODE fields: dev = tohost_q[63:56], cmd = tohost_q[55:48].
  - dev == 0 and tohost_q[0] == 1 → exit. end_of_test_o <= tohost_q[31:0]. Go to DONE.
  - dev == 1 and cmd == 1 → load char_o <= tohost_q[7:0]. Go to CHAR_OUT.
  - Anything else, including tohost_q == 0 and dev == 0 with bit0 == 0 → go to ACK with no side effect.
- CHAR_OUT: char_valid_o = 1, and char_o holds stable until char_ready_i = 1. On the ready cycle, go to ACK.
- ACK (one cycle): tohost_q <= 0, fromhost_q <= {dev, cmd, 48'h0}, go to IDLE.
- fromhost_q is cleared only by a core write. A core write to fromhost_q has no side effect.
- DONE: sticky until reset.
  - end_of_test_o is frozen.
  - Accesses are still granted and answered, so the core never hangs.
  - tohost writes merge into the register but do not trigger.
- Timeout:
  - A 32-bit cycle counter starts at 0 on reset and increments every cycle; it saturates.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES while not in DONE: end_of_test_o <= 32'hFFFF_FFFF and go to DONE from any state.
  - char_valid_o is dropped in that same cycle.
  - If an exit and the timeout occur in the same cycle, the exit wins.

## Timing
- Reset values (all outputs and state):
  - gnt_o = 0, rvalid_o = 0, rdata_o = 0.
  - char_valid_o = 0, char_o = 0.
  - end_of_test_o = 0, busy_o = 0.
  - tohost_q = 0, fromhost_q = 0, state = IDLE, counter = 0.
- Reset has priority over every other event, including mid-CHAR_OUT and in DONE.
- Grant at cycle N → rvalid_o = 1 at N+1.
  - rdata_o is the register value after the cycle-N write. A read and a write cannot occur in the same cycle.
  - rdata_o = 0 on write responses.
- Trigger write granted at N:
  - DECODE at N+1.
  - Exit → end_of_test_o valid from N+2.
  - Putchar → char_valid_o from N+2.
  - Ready at cycle R → ACK at R+1 → tohost_q reads 0 from R+2; IDLE and gnt_o are possible at R+2.
- Unknown command: ACK at N+2, IDLE at N+3.
- Maximum read-to-read interval in IDLE: 1 cycle (back-to-back grants).

## Test plan
- Exit: write 64'h0000_0000_0000_002B to TOHOST_ADDR, be = FF → end_of_test_o = 32'h0000_002B at trigger+2, and it stays there for 100 cycles while further writes are ignored.
- Putchar with backpressure: write 64'h0101_0000_0000_0041, with char_ready_i low for 5 cycles → char_valid_o = 1 and char_o = 8'h41 held stable for 6 cycles. After that, tohost reads 0 and fromhost reads 64'h0101_0000_0000_0000.
- RV32 split write: be = 0F with 32'h0000_0001, then be = F0 with 32'h0 → no trigger after the first write; after the second, end_of_test_o = 32'h1.
- Stall: issue a fromhost read while in CHAR_OUT → gnt_o = 0 until ACK completes, then the grant follows and rvalid_o comes one cycle later.
- Timeout: TIMEOUT_CYCLES = 50, no traffic → end_of_test_o = 32'hFFFF_FFFF at cycle 51. Repeat with the exit landing on the same cycle → the exit word wins.
- Reset mid-operation: assert rst_i during CHAR_OUT → the next cycle has char_valid_o = 0, state IDLE, and both registers 0.
